branch_resolution_unit: RTL
===========================

Name: branch_resolution_unit

Overview:
Execute-side counterpart of the branch target buffer. Tracks every branch predicted at fetch/decode in an in-order prediction queue and checks each one against the actual outcome at execute. Drives the BTB update feedback (hit, target) and the fetch redirect/flush on mispredict. Sits between decode/execute and the BTB/fetch stage.

Parameters:
PC_W, `PC_SIZE, PC width in bits.
PQ_DEPTH, 4, prediction queue entries; power of two, ≥2.
CNT_W, 16, statistics counter width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
dec_valid  in  1  decode presents a branch this cycle
dec_pc  in  PC_W  PC of that branch
dec_pred_hit  in  1  BTB predicted taken (BTB hit at fetch)
dec_pred_target  in  PC_W  BTB-predicted target
dec_stall  out  1  queue full; decode must hold the branch
ex_valid  in  1  execute resolves the oldest branch
ex_taken  in  1  actual direction
ex_target  in  PC_W  actual taken target
ext_flush  in  1  flush from a non-branch source (e.g. exception)
fb_hit  out  1  BTB write strobe: install/refresh the entry
fb_pc  out  PC_W  PC of the resolved branch
fb_target  out  PC_W  target to install
redirect_valid  out  1  mispredict; fetch must restart
redirect_pc  out  PC_W  restart PC
err_underflow  out  1  sticky: ex_valid seen with queue empty
stat_branches  out  CNT_W  resolved branches, saturating
stat_mispredicts  out  CNT_W  mispredicts, saturating

Behaviour:
- Reset: queue empty (head = tail = count = 0); all outputs 0; dec_stall = 0.
- Enqueue: dec_valid & ~dec_stall writes {pc, pred_hit, pred_target} at the tail on the clock edge.
- dec_stall = (count == PQ_DEPTH), combinational from count only, with no path from ex_valid.
- Resolve: ex_valid & count != 0 pops the head. Mispredict when pred_hit != ex_taken, or when pred_hit & ex_taken & pred_target != ex_target.
- Outputs are registered with 1-cycle latency after a resolve:
  - fb_pc = head.pc.
  - fb_hit = ex_taken. Not-taken resolves do not write the BTB; BTB entries are never invalidated.
  - fb_target = ex_target.
  - redirect_valid = mispredict.
  - redirect_pc = ex_target if taken, else head.pc + 1, modulo 2^PC_W; wrap from all-ones to 0 is legal.
- fb_hit and redirect_valid are single-cycle pulses. All fb_* and redirect_pc are held at their last value when no pulse is active.
- Mispredict flush: on the resolving edge, the queue empties (count = 0, head = tail). A dec_valid in the same cycle is dropped: flush wins, the entry is wrong-path.
- ext_flush: queue empties next edge with no feedback or redirect. If it coincides with ex_valid, the resolve is still reported (fb/redirect/stats) and the queue still ends empty.
- Simultaneous enqueue and correct resolve: count is unchanged; the ring pointers wrap modulo PQ_DEPTH.
- Underflow: ex_valid with count == 0 sets err_underflow, which stays set until reset. No pop, no outputs.
- Statistics: stat_branches += 1 per valid resolve, stat_mispredicts += 1 per mispredict. Both saturate at all-ones.
- A rst asserted mid-operation discards all entries and pulses within one edge.

Decomposition:
- Shared package nand_cpu_pkg holds:
  - PQ entry typedef {pc, pred_hit, pred_target}.
  - Feedback typedef {hit, pc, target}, reused by the BTB update path.
- One natural sub-module: pred_queue, a parameterised flush-able ring FIFO with count, full/empty, push, pop, flush.
- Compare logic, output registers and counters live in the top module.

Test Plan:
1. Reset, then enqueue pc=0x10 pred_hit=1 target=0x40; resolve taken target=0x40 -> next cycle fb_hit=1, fb_pc=0x10, fb_target=0x40, redirect_valid=0, stat_branches=1.
2. Enqueue pc=0x20 pred_hit=0; resolve taken target=0x80 -> fb_hit=1, redirect_valid=1, redirect_pc=0x80, stat_mispredicts=1.
3. Enqueue pc=0x30 pred_hit=1 target=0x50; resolve not taken -> fb_hit=0, redirect_valid=1, redirect_pc=0x31. Then pc=0x30 pred_hit=1 target=0x50, resolved taken target=0x60 -> redirect_pc=0x60.
4. Enqueue 4 branches -> dec_stall=1. A 5th dec_valid is not accepted. Resolve head correctly -> stall drops; queue order is preserved over 10 push/pop cycles across pointer wrap.
5. Three queued, first mispredicts while dec_valid=1 -> queue empty, new entry dropped. A following ex_valid sets err_underflow=1, which persists until rst.
6. Drive stat counters to all-ones via CNT_W=4 and 20 mispredicts -> both counters read 0xF. Then assert rst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/nand_cpu_pkg.sv
// Shared branch-path types: prediction-queue entry and BTB feedback record.
// Pure declarations; no logic, no latency.
`ifndef PC_SIZE
`define PC_SIZE 16
`endif

package nand_cpu_pkg;

  localparam int PC_SIZE = `PC_SIZE;

  typedef struct packed {
    logic [PC_SIZE-1:0] pc;
    logic               pred_hit;
    logic [PC_SIZE-1:0] pred_target;
  } pq_entry_t;

  typedef struct packed {
    logic               hit;
    logic [PC_SIZE-1:0] pc;
    logic [PC_SIZE-1:0] target;
  } btb_fb_t;

  // Fall-through PC; all-ones wraps to zero.
  function automatic logic [PC_SIZE-1:0] pc_next(input logic [PC_SIZE-1:0] pc);
    return pc + 1'b1;
  endfunction

endpackage

// File: rtl/branch_resolution_unit_pred_queue.sv
// In-order ring FIFO of predicted branches with single-edge flush.
// Push ignored when full or flushing; pop ignored when empty; head is read combinationally.
module pred_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push & ~full & ~flush;
  assign do_pop    = pop & ~empty;
  assign head_data = mem[head];

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= push_data;
  end

endmodule

// File: rtl/branch_resolution_unit.sv
// Checks queued branch predictions against execute outcomes; drives BTB update and fetch redirect.
// Outputs registered one cycle after a resolve; decode stalls only when the queue is full.
module branch_resolution_unit
  import nand_cpu_pkg::*;
#(
  parameter int PC_W     = `PC_SIZE,
  parameter int PQ_DEPTH = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [PC_W-1:0]  dec_pc,
  input  logic             dec_pred_hit,
  input  logic [PC_W-1:0]  dec_pred_target,
  output logic             dec_stall,
  input  logic             ex_valid,
  input  logic             ex_taken,
  input  logic [PC_W-1:0]  ex_target,
  input  logic             ext_flush,
  output logic             fb_hit,
  output logic [PC_W-1:0]  fb_pc,
  output logic [PC_W-1:0]  fb_target,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             err_underflow,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  pq_entry_t push_entry;
  pq_entry_t head;
  btb_fb_t   fb_q;
  logic      q_full;
  logic      q_empty;
  logic      resolve;
  logic      mispredict;
  logic      flush;

  assign push_entry = '{pc: dec_pc, pred_hit: dec_pred_hit, pred_target: dec_pred_target};

  assign resolve    = ex_valid & ~q_empty;
  assign mispredict = (head.pred_hit != ex_taken) ||
                      (head.pred_hit && ex_taken && (head.pred_target != ex_target));
  // Wrong-path decode in the flush cycle is dropped inside the queue.
  assign flush      = (resolve & mispredict) | ext_flush;
  assign dec_stall  = q_full;

  pred_queue #(
    .WIDTH ($bits(pq_entry_t)),
    .DEPTH (PQ_DEPTH)
  ) u_pred_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (dec_valid),
    .push_data (push_entry),
    .pop       (resolve),
    .flush     (flush),
    .head_data (head),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign fb_hit    = fb_q.hit;
  assign fb_pc     = fb_q.pc;
  assign fb_target = fb_q.target;

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_q             <= '0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      err_underflow    <= 1'b0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      fb_q.hit       <= 1'b0;
      redirect_valid <= 1'b0;
      if (resolve) begin
        fb_q           <= '{hit: ex_taken, pc: head.pc, target: ex_target};
        redirect_valid <= mispredict;
        redirect_pc    <= ex_taken ? ex_target : pc_next(head.pc);
        if (stat_branches != '1) stat_branches <= stat_branches + 1'b1;
        if (mispredict && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + 1'b1;
      end
      if (ex_valid && q_empty) err_underflow <= 1'b1;
    end
  end

endmodule
